// File: rtl/line_encoder.sv
// Sequential 8-to-3 request encoder with pending register and ack-clear.
// Fixed (MSB-first) or rotating priority selected by ROUND_ROBIN.
module line_encoder #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] D,
  input  logic       ack,
  output logic [2:0] A,
  output logic       valid,
  output logic [7:0] pend
);

  logic [7:0] pending_q, pending_d;
  logic [2:0] last_q, last_d;
  logic [2:0] sel;
  logic [2:0] idx;
  logic [7:0] clr;
  logic       take;

  always_comb begin
    sel = 3'd0;
    idx = 3'd0;
    if (ROUND_ROBIN) begin
      // Walk the search order backwards so the earliest hit wins.
      for (int k = 8; k >= 1; k--) begin
        idx = last_q + 3'(k);
        if (pending_q[idx]) sel = idx;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) sel = 3'(i);
      end
    end
  end

  assign valid = |pending_q;
  assign A     = valid ? sel : 3'd0;
  assign pend  = pending_q;
  assign take  = valid & ack;

  always_comb begin
    clr       = take ? (8'b1 << A) : 8'h00;
    pending_d = (pending_q & ~clr) | D;
    last_d    = take ? A : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      last_q    <= 3'd7;
    end else begin
      pending_q <= pending_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_line_encoder.sv
// Bench for line_encoder: fixed-priority vector table plus
// rotating-priority sequences, checked through an expectation queue.
module tb_line_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_f = 8'h00, d_r = 8'h00;
  logic       ack_f = 1'b0, ack_r = 1'b0;
  logic [2:0] a_f, a_r;
  logic       v_f, v_r;
  logic [7:0] p_f, p_r;

  always #5 clk = ~clk;

  line_encoder #(.ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .D(d_f), .ack(ack_f),
    .A(a_f), .valid(v_f), .pend(p_f)
  );

  line_encoder #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .D(d_r), .ack(ack_r),
    .A(a_r), .valid(v_r), .pend(p_r)
  );

  typedef struct {
    bit         rst;
    logic [7:0] d;
    bit         ack;
    logic [2:0] a;
    bit         v;
    logic [7:0] p;
  } vec_t;

  typedef struct {
    bit         rr;
    logic [2:0] a;
    bit         v;
    logic [7:0] p;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic apply(input bit rr, input bit rst,
                       input logic [7:0] d, input bit ack,
                       input logic [2:0] a, input bit v,
                       input logic [7:0] p, input string nm);
    exp_t e, got;
    rst_n = ~rst;
    if (rr) begin
      d_r = d; ack_r = ack; d_f = 8'h00; ack_f = 1'b0;
    end else begin
      d_f = d; ack_f = ack; d_r = 8'h00; ack_r = 1'b0;
    end
    e.rr = rr; e.a = a; e.v = v; e.p = p; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    tests++;
    if (got.rr ? (a_r !== got.a || v_r !== got.v || p_r !== got.p)
               : (a_f !== got.a || v_f !== got.v || p_f !== got.p)) begin
      fails++;
      if (got.rr)
        $display("FAIL %s: got A=%0d v=%0b pend=%h, want A=%0d v=%0b pend=%h",
                 got.nm, a_r, v_r, p_r, got.a, got.v, got.p);
      else
        $display("FAIL %s: got A=%0d v=%0b pend=%h, want A=%0d v=%0b pend=%h",
                 got.nm, a_f, v_f, p_f, got.a, got.v, got.p);
    end
  endtask

  vec_t fv[16];

  initial begin
    fv[0]  = '{1, 8'hFF, 0, 3'd0, 0, 8'h00};
    fv[1]  = '{1, 8'hFF, 0, 3'd0, 0, 8'h00};
    fv[2]  = '{0, 8'hFF, 0, 3'd7, 1, 8'hFF};
    fv[3]  = '{1, 8'h00, 1, 3'd0, 0, 8'h00};
    fv[4]  = '{0, 8'h00, 1, 3'd0, 0, 8'h00};
    fv[5]  = '{0, 8'hA4, 0, 3'd7, 1, 8'hA4};
    fv[6]  = '{0, 8'h00, 1, 3'd5, 1, 8'h24};
    fv[7]  = '{0, 8'h00, 1, 3'd2, 1, 8'h04};
    fv[8]  = '{0, 8'h00, 1, 3'd0, 0, 8'h00};
    fv[9]  = '{0, 8'h80, 0, 3'd7, 1, 8'h80};
    fv[10] = '{0, 8'h80, 1, 3'd7, 1, 8'h80};
    fv[11] = '{0, 8'h01, 1, 3'd0, 1, 8'h01};
    fv[12] = '{0, 8'h04, 0, 3'd2, 1, 8'h05};
    fv[13] = '{0, 8'h00, 0, 3'd2, 1, 8'h05};
    fv[14] = '{0, 8'h02, 1, 3'd1, 1, 8'h03};
    fv[15] = '{0, 8'h00, 0, 3'd1, 1, 8'h03};

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      apply(0, fv[i].rst, fv[i].d, fv[i].ack,
            fv[i].a, fv[i].v, fv[i].p, $sformatf("fix_vec%0d", i));

    apply(1, 1, 8'hFF, 1, 3'd0, 0, 8'h00, "rr_reset");
    apply(1, 0, 8'h00, 1, 3'd0, 0, 8'h00, "rr_idle_ack");
    apply(1, 0, 8'hFF, 0, 3'd0, 1, 8'hFF, "rr_first");
    for (int k = 1; k <= 9; k++)
      apply(1, 0, 8'hFF, 1, 3'(k), 1, 8'hFF,
            $sformatf("rr_fair%0d", k));

    apply(1, 1, 8'h00, 0, 3'd0, 0, 8'h00, "rr_reset2");
    apply(1, 0, 8'h40, 0, 3'd6, 1, 8'h40, "rr_load6");
    apply(1, 0, 8'h03, 1, 3'd0, 1, 8'h03, "rr_wrap0");
    apply(1, 0, 8'h00, 1, 3'd1, 1, 8'h02, "rr_wrap1");
    apply(1, 0, 8'h00, 1, 3'd0, 0, 8'h00, "rr_wrap_idle");

    apply(1, 1, 8'h00, 0, 3'd0, 0, 8'h00, "rr_reset3");
    apply(1, 0, 8'h0F, 0, 3'd0, 1, 8'h0F, "rr_load0f");
    apply(1, 0, 8'h00, 1, 3'd1, 1, 8'h0E, "rr_serve0");
    apply(1, 1, 8'hFF, 1, 3'd0, 0, 8'h00, "rr_mid_reset");
    apply(1, 0, 8'h81, 0, 3'd0, 1, 8'h81, "rr_last7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
